// File: rtl/noc_rr_lock_arb.sv
// Output-port switch arbiter: multicast-over-unicast class priority, round-robin within class,
// wormhole lock held until tail transfer, with unicast ageing against multicast starvation.

module noc_rr_pick #(
  parameter int N     = 5,
  parameter int RR_EN = 1,
  parameter int PW    = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          vld_o,
  output logic [PW-1:0] idx_o
);
  // Scan from the highest offset down so the lowest offset from the pointer is the last (winning) write.
  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    for (int off = N - 1; off >= 0; off--) begin
      if (req_i[(((RR_EN != 0) ? int'(ptr_i) : 0) + off) % N]) begin
        vld_o = 1'b1;
        idx_o = PW'((((RR_EN != 0) ? int'(ptr_i) : 0) + off) % N);
      end
    end
  end
endmodule

module noc_rr_lock_arb #(
  parameter int PORT_NUM = 5,
  parameter int RR_EN    = 1,
  parameter int AGE_MAX  = 8
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [PORT_NUM-1:0] u_req,
  input  logic [PORT_NUM-1:0] m_req,
  input  logic [PORT_NUM-1:0] multab_ct,
  input  logic                flit_fire,
  input  logic                flit_tail,
  output logic [PORT_NUM-1:0] grt,
  output logic                grt_valid,
  output logic                grt_mcast,
  output logic                grt_abort
);
  localparam int PTR_W = $clog2(PORT_NUM);
  localparam int AGE_W = (AGE_MAX == 0) ? 1 : $clog2(AGE_MAX + 1);
  localparam logic [AGE_W-1:0] AGE_TOP = AGE_W'(AGE_MAX);
  localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(PORT_NUM - 1);
  localparam logic [PORT_NUM-1:0] ONE  = PORT_NUM'(1);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e              state_q, state_d;
  logic [PORT_NUM-1:0] grt_q, grt_d;
  logic                mcast_q, mcast_d;
  logic                abort_q, abort_d;
  logic [PTR_W-1:0]    mptr_q, mptr_d;
  logic [PTR_W-1:0]    uptr_q, uptr_d;
  logic [AGE_W-1:0]    age_q, age_d;

  logic [PORT_NUM-1:0] m_elig;
  logic                m_vld, u_vld, force_u, own_req;
  logic [PTR_W-1:0]    m_idx, u_idx;

  // Contention only masks multicast at arbitration time; an existing lock ignores it.
  assign m_elig  = m_req & ~multab_ct;
  assign force_u = (AGE_MAX != 0) && (age_q == AGE_TOP) && (|u_req);
  assign own_req = mcast_q ? |(grt_q & m_req) : |(grt_q & u_req);

  noc_rr_pick #(.N(PORT_NUM), .RR_EN(RR_EN), .PW(PTR_W)) u_mpick (
    .req_i(m_elig), .ptr_i(mptr_q), .vld_o(m_vld), .idx_o(m_idx)
  );
  noc_rr_pick #(.N(PORT_NUM), .RR_EN(RR_EN), .PW(PTR_W)) u_upick (
    .req_i(u_req),  .ptr_i(uptr_q), .vld_o(u_vld), .idx_o(u_idx)
  );

  always_comb begin
    state_d = state_q;
    grt_d   = grt_q;
    mcast_d = mcast_q;
    abort_d = 1'b0;
    mptr_d  = mptr_q;
    uptr_d  = uptr_q;
    age_d   = age_q;
    case (state_q)
      IDLE: begin
        if (m_vld && !force_u) begin
          state_d = HOLD;
          grt_d   = ONE << m_idx;
          mcast_d = 1'b1;
          mptr_d  = (m_idx == PTR_TOP) ? '0 : m_idx + 1'b1;
          if ((|u_req) && (age_q != AGE_TOP)) age_d = age_q + 1'b1;
        end else if (u_vld) begin
          state_d = HOLD;
          grt_d   = ONE << u_idx;
          mcast_d = 1'b0;
          uptr_d  = (u_idx == PTR_TOP) ? '0 : u_idx + 1'b1;
          age_d   = '0;
        end
      end
      HOLD: begin
        // Tail transfer wins over a coincident withdrawal, so no abort in that case.
        if (flit_fire && flit_tail) begin
          state_d = IDLE;
          grt_d   = '0;
          mcast_d = 1'b0;
        end else if (!own_req) begin
          state_d = IDLE;
          grt_d   = '0;
          mcast_d = 1'b0;
          abort_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grt_d   = '0;
        mcast_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      grt_q   <= '0;
      mcast_q <= 1'b0;
      abort_q <= 1'b0;
      mptr_q  <= '0;
      uptr_q  <= '0;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      grt_q   <= grt_d;
      mcast_q <= mcast_d;
      abort_q <= abort_d;
      mptr_q  <= mptr_d;
      uptr_q  <= uptr_d;
      age_q   <= age_d;
    end
  end

  assign grt       = grt_q;
  assign grt_valid = |grt_q;
  assign grt_mcast = mcast_q;
  assign grt_abort = abort_q;
endmodule
